// File: rtl/ps2_tx_if.sv
// ps2_tx_if: start/data handshake, status pulses and open-drain pad signals of the PS/2 host transmitter.
interface ps2_tx_if;
    logic       start;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    modport master (
        output start, data, ps2_clk_in, ps2_dat_in,
        input  ready, busy, done, error, ps2_clk_oe, ps2_dat_oe
    );
    modport slave (
        input  start, data, ps2_clk_in, ps2_dat_in,
        output ready, busy, done, error, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device transmitter; inhibits the clock, requests to send, shifts out one byte
// with odd parity on device clock falls, checks the ACK and guards the whole exchange with a watchdog.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 2600,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input logic     clk,
    input logic     rst_n,
    ps2_tx_if.slave bus
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYCLES);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic [2:0]    r_state;
    logic          r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic [9:0]    r_frame;
    logic          r_cur;
    logic [3:0]    r_bit_cnt;
    logic [IW-1:0] r_inh;
    logic [WW-1:0] r_wd;
    logic          r_ack_ok;
    logic          w_fall, w_wd_on, w_wd_exp, w_done, w_error;

    assign w_fall   = r_clk_prev & ~r_clk_s2;
    assign w_wd_on  = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT);
    assign w_wd_exp = w_wd_on && (r_wd == '0);
    assign w_error  = w_wd_exp || ((r_state == S_ACK) && w_fall && r_dat_s2);
    assign w_done   = !w_wd_exp && (r_state == S_WAIT) && r_ack_ok && r_clk_s2 && r_dat_s2;

    assign bus.ready      = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = w_done;
    assign bus.error      = w_error;
    assign bus.ps2_clk_oe = (r_state == S_INHIBIT) || (r_state == S_REQ);
    // an expired watchdog releases the data line in the same cycle the error is flagged
    assign bus.ps2_dat_oe = (r_state == S_REQ) || ((r_state == S_SEND) && !w_wd_exp && !r_cur);

    // idle lines sit high, so the synchronisers come out of reset high to avoid a phantom fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= bus.ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_cur     <= 1'b0;
            r_bit_cnt <= '0;
            r_inh     <= '0;
            r_wd      <= '0;
            r_ack_ok  <= 1'b0;
        end else begin
            if (w_wd_on) r_wd <= w_fall ? WD_LOAD : r_wd - WW'(1);
            if (w_error || w_done) r_state <= S_IDLE;
            else case (r_state)
                S_IDLE: if (bus.start) begin
                    r_frame   <= {1'b1, ~^bus.data, bus.data};
                    r_inh     <= '0;
                    r_bit_cnt <= '0;
                    r_cur     <= 1'b0;
                    r_ack_ok  <= 1'b0;
                    r_state   <= S_INHIBIT;
                end
                S_INHIBIT: begin
                    r_inh <= r_inh + IW'(1);
                    if (r_inh == INH_LAST) r_state <= S_REQ;
                end
                S_REQ: begin
                    r_wd    <= WD_LOAD;
                    r_state <= S_SEND;
                end
                S_SEND: if (w_fall) begin
                    r_cur     <= r_frame[r_bit_cnt];
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd9) r_state <= S_ACK;
                end
                S_ACK: if (w_fall) begin
                    r_ack_ok <= 1'b1;
                    r_state  <= S_WAIT;
                end
                S_WAIT:  r_state <= S_WAIT;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
